// File: rtl/bcd_temp_pkg.sv
// Shared definitions for the BCD-to-temperature conversion path: result width,
// special digit codes, FSM state encoding and the tenths-to-sixteenths rounding LUT.
package bcd_temp_pkg;

  localparam int TEMP_W = 13;

  localparam logic [3:0] DIG_MINUS = 4'd10;
  localparam logic [3:0] DIG_BLANK = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CHECK    = 3'd1,
    S_MUL      = 3'd2,
    S_ASSEMBLE = 3'd3,
    S_DONE     = 3'd4
  } state_e;

  // round(tenths * 1.6); blank and anything illegal map to 0
  function automatic logic [3:0] tenths_lut(input logic [3:0] t);
    logic [3:0] s;
    case (t)
      4'd1:    s = 4'd2;
      4'd2:    s = 4'd3;
      4'd3:    s = 4'd5;
      4'd4:    s = 4'd6;
      4'd5:    s = 4'd8;
      4'd6:    s = 4'd10;
      4'd7:    s = 4'd11;
      4'd8:    s = 4'd13;
      4'd9:    s = 4'd14;
      default: s = 4'd0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/tenths_to_sixteenths.sv
// Maps a tenths digit (0..9 or blank) to sixteenths of a degree and flags
// whether the digit code is legal. Purely combinational.
module tenths_to_sixteenths
  import bcd_temp_pkg::*;
(
  input  logic [3:0] tenths,
  output logic [3:0] sixteenths,
  output logic       legal
);

  // LUT lookup plus legality of the digit code
  always_comb begin
    sixteenths = tenths_lut(tenths);
    legal      = (tenths <= 4'd9) || (tenths == DIG_BLANK);
  end

endmodule

// File: rtl/bcd_to_temp.sv
// BCD display-style temperature (sign, tens, ones, tenths) to 13-bit two's
// complement in 1/16 degC. Tens digit is multiplied by repeated add-10.
// Optional build macro BCD_TO_TEMP_OFFSET_EN adds a whole-degree offset input
// that is added to the signed result in ASSEMBLE.
//
// state      | meaning
// S_IDLE     | waiting for start; digits captured on start
// S_CHECK    | validate digit codes, preload multiplier
// S_MUL      | acc += 10 per cycle until cnt reaches 0
// S_ASSEMBLE | build magnitude, apply sign (and offset), load temp
// S_DONE     | conversion final; done/err reported next cycle
module bcd_to_temp
  import bcd_temp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        d3,
  input  logic [3:0]        d2,
  input  logic [3:0]        d1,
  input  logic [3:0]        d0,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [TEMP_W-1:0] temp
`ifdef BCD_TO_TEMP_OFFSET_EN
  ,
  input  logic [6:0]        offset
`endif
);

  state_e state_q, state_d;
  logic [3:0] d3_q, d3_d, d2_q, d2_d, d1_q, d1_d, d0_q, d0_d;
  logic [6:0] acc_q, acc_d;
  logic [3:0] cnt_q, cnt_d;
  logic       busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [TEMP_W-1:0] temp_q, temp_d;

  logic [3:0]        frac;
  logic              d0_legal;
  logic              legal;
  logic              neg;
  logic [6:0]        whole;
  logic [10:0]       mag;
  logic [TEMP_W-1:0] smag;
  logic [TEMP_W-1:0] result;

  tenths_to_sixteenths u_frac (
    .tenths     (d0_q),
    .sixteenths (frac),
    .legal      (d0_legal)
  );

  // Legality, magnitude assembly and sign/offset application
  always_comb begin
    legal  = ((d3_q == DIG_MINUS) || (d3_q == DIG_BLANK)) &&
             (d2_q <= 4'd9) && (d1_q <= 4'd9) && d0_legal;
    neg    = (d3_q == DIG_MINUS);
    whole  = acc_q + {3'd0, d1_q};
    mag    = {whole, 4'd0} + {7'd0, frac};
    smag   = neg ? (13'd0 - {2'd0, mag}) : {2'd0, mag};
`ifdef BCD_TO_TEMP_OFFSET_EN
    result = smag + {2'd0, offset, 4'd0};
`else
    result = smag;
`endif
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start) state_d = S_CHECK;
      S_CHECK:    state_d = legal ? S_MUL : S_DONE;
      S_MUL:      if (cnt_q == 4'd0) state_d = S_ASSEMBLE;
      S_ASSEMBLE: state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Handshake outputs, registered so done lands one cycle after S_DONE
  always_comb begin
    busy_d = (state_q == S_CHECK) || (state_q == S_MUL) || (state_q == S_ASSEMBLE);
    done_d = (state_q == S_DONE);
  end

  // Datapath next values: capture, multiply by repeated add, result load
  always_comb begin
    d3_d   = d3_q;
    d2_d   = d2_q;
    d1_d   = d1_q;
    d0_d   = d0_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    temp_d = temp_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          d3_d = d3;
          d2_d = d2;
          d1_d = d1;
          d0_d = d0;
        end
      end
      S_CHECK: begin
        err_d = ~legal;
        acc_d = 7'd0;
        cnt_d = d2_q;
      end
      S_MUL: begin
        if (cnt_q != 4'd0) begin
          acc_d = acc_q + 7'd10;
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ASSEMBLE: temp_d = result;
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d3_q   <= 4'd0;
      d2_q   <= 4'd0;
      d1_q   <= 4'd0;
      d0_q   <= 4'd0;
      acc_q  <= 7'd0;
      cnt_q  <= 4'd0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      temp_q <= '0;
    end else begin
      d3_q   <= d3_d;
      d2_q   <= d2_d;
      d1_q   <= d1_d;
      d0_q   <= d0_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q  <= err_d;
      temp_q <= temp_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;
  assign temp = temp_q;

endmodule

// File: tb/tb_bcd_to_temp.sv
// Directed bench for bcd_to_temp: latency, busy width, results, error path,
// start-while-busy, and asynchronous reset abort.
module tb_bcd_to_temp;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  d3, d2, d1, d0;
  logic        busy, done, err;
  logic [12:0] temp;
`ifdef BCD_TO_TEMP_OFFSET_EN
  logic [6:0]  offset;
`endif

  int n_cmp = 0;
  int n_err = 0;

  bcd_to_temp dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .d3    (d3),
    .d2    (d2),
    .d1    (d1),
    .d0    (d0),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .temp  (temp)
`ifdef BCD_TO_TEMP_OFFSET_EN
    ,
    .offset(offset)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Pulse start with the given digits, then watch 40 cycles. lat = cycle of first
  // done (0 if none), bcnt = busy-high cycles before it, dcnt = total done pulses.
  // If inj > 0, a second start with -12.5 is pulsed so that it is sampled on edge inj+1.
  task automatic run(input logic [3:0] a3, input logic [3:0] a2, input logic [3:0] a1,
                     input logic [3:0] a0, input int inj,
                     output int lat, output int bcnt, output int dcnt);
    lat = 0; bcnt = 0; dcnt = 0;
    @(posedge clk); #1;
    d3 = a3; d2 = a2; d1 = a1; d0 = a0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    d3 = 4'd0; d2 = 4'd0; d1 = 4'd0; d0 = 4'd0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin
        dcnt++;
        if (lat == 0) lat = k;
      end
      if (lat == 0 && busy) bcnt++;
      if (k == inj) begin
        d3 = 4'd10; d2 = 4'd1; d1 = 4'd2; d0 = 4'd5; start = 1'b1;
      end else if (k == inj + 1) begin
        start = 1'b0;
        d3 = 4'd0; d2 = 4'd0; d1 = 4'd0; d0 = 4'd0;
      end
    end
  endtask

  int lat, bcnt, dcnt;

  initial begin
    rst = 1'b0; start = 1'b0;
    d3 = 4'd0; d2 = 4'd0; d1 = 4'd0; d0 = 4'd0;
`ifdef BCD_TO_TEMP_OFFSET_EN
    offset = 7'd0;
`endif
    #23;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err",  {31'd0, err},  32'd0);
    chk("rst_temp", {19'd0, temp}, 32'd0);
    rst = 1'b1;

    // +25.0 -> 400
    run(4'd15, 4'd2, 4'd5, 4'd0, -5, lat, bcnt, dcnt);
    chk("p25_lat",  lat, 6);
    chk("p25_busy", bcnt, 5);
    chk("p25_temp", {19'd0, temp}, 32'h190);
    chk("p25_err",  {31'd0, err}, 32'd0);
    chk("p25_dcnt", dcnt, 1);

    // -12.5 -> -200
    run(4'd10, 4'd1, 4'd2, 4'd5, -5, lat, bcnt, dcnt);
    chk("m125_lat",  lat, 5);
    chk("m125_temp", {19'd0, temp}, 32'h1F38);

    // -00.0 -> 0
    run(4'd10, 4'd0, 4'd0, 4'd0, -5, lat, bcnt, dcnt);
    chk("m000_lat",  lat, 4);
    chk("m000_temp", {19'd0, temp}, 32'd0);

    // +99.9 -> 1598
    run(4'd15, 4'd9, 4'd9, 4'd9, -5, lat, bcnt, dcnt);
    chk("p999_lat",  lat, 13);
    chk("p999_busy", bcnt, 12);
    chk("p999_temp", {19'd0, temp}, 32'h63E);

    // illegal units digit after a 400 result
    run(4'd15, 4'd2, 4'd5, 4'd0, -5, lat, bcnt, dcnt);
    run(4'd15, 4'd2, 4'd12, 4'd0, -5, lat, bcnt, dcnt);
    chk("ill_d1_lat",  lat, 2);
    chk("ill_d1_err",  {31'd0, err}, 32'd1);
    chk("ill_d1_temp", {19'd0, temp}, 32'd400);

    // +07.3 -> 117, clears err
    run(4'd15, 4'd0, 4'd7, 4'd3, -5, lat, bcnt, dcnt);
    chk("p073_lat",  lat, 4);
    chk("p073_err",  {31'd0, err}, 32'd0);
    chk("p073_temp", {19'd0, temp}, 32'd117);

    // illegal sign code and illegal tenths code
    run(4'd3, 4'd1, 4'd1, 4'd1, -5, lat, bcnt, dcnt);
    chk("ill_d3_err",  {31'd0, err}, 32'd1);
    chk("ill_d3_temp", {19'd0, temp}, 32'd117);
    run(4'd15, 4'd1, 4'd1, 4'd12, -5, lat, bcnt, dcnt);
    chk("ill_d0_err",  {31'd0, err}, 32'd1);
    run(4'd15, 4'd10, 4'd1, 4'd1, -5, lat, bcnt, dcnt);
    chk("ill_d2_lat", lat, 2);

    // -05.<blank> -> -80
    run(4'd10, 4'd0, 4'd5, 4'd15, -5, lat, bcnt, dcnt);
    chk("m05b_err",  {31'd0, err}, 32'd0);
    chk("m05b_temp", {19'd0, temp}, 32'h1FB0);

    // start during MUL is ignored
    run(4'd15, 4'd9, 4'd9, 4'd9, 3, lat, bcnt, dcnt);
    chk("ign_lat",  lat, 13);
    chk("ign_temp", {19'd0, temp}, 32'd1598);
    chk("ign_dcnt", dcnt, 1);

    // reset mid-MUL aborts, no done afterwards
    @(posedge clk); #1;
    d3 = 4'd15; d2 = 4'd9; d1 = 4'd9; d0 = 4'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    chk("mid_busy_pre", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_temp", {19'd0, temp}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    dcnt = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    chk("arst_nodone", dcnt, 0);

`ifdef BCD_TO_TEMP_OFFSET_EN
    offset = 7'd20;
    run(4'd15, 4'd2, 4'd5, 4'd0, -5, lat, bcnt, dcnt);
    chk("ofs_temp", {19'd0, temp}, 32'd720);
    offset = 7'd0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
